// File: rtl/bus_master_req_if.sv
// Command, status and bus-side signals of one bus master requester.
// master: the requester itself; slave: the local agent / arbiter side.
interface bus_master_req_if #(
   parameter int LEN_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic             data_stall;
   logic             gnt;
   logic             req;
   logic             frame;
   logic             irdy;
   logic             bus_oe;
   logic             beat;
   logic [LEN_W-1:0] beat_idx;
   logic             xfer_done;
   logic             gnt_err;
   logic             busy;

   modport master (
      input  cmd_valid, cmd_len, data_stall, gnt,
      output cmd_ready, req, frame, irdy, bus_oe, beat, beat_idx, xfer_done, gnt_err, busy
   );

   modport slave (
      output cmd_valid, cmd_len, data_stall, gnt,
      input  cmd_ready, req, frame, irdy, bus_oe, beat, beat_idx, xfer_done, gnt_err, busy
   );
endinterface

// File: rtl/bus_master_req.sv
// Bus master requester: command -> req/gnt -> frame/irdy burst -> one-cycle frame&&irdy done.
// All outputs registered; req falls 1 cycle after acceptance; commands held off (cmd_ready=0) outside IDLE.
module bus_master_req #(
   parameter int LEN_W       = 4,
   parameter int GNT_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   bus_master_req_if.master bus
);

   localparam int                WAIT_W    = $clog2(GNT_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GNT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_XFER,
      S_DONE,
      S_ABORT
   } state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              last_q, last_d;

   logic             cmd_ready_d, busy_d;
   logic             req_d, frame_d, irdy_d, bus_oe_d;
   logic             beat_d, xfer_done_d, gnt_err_d;
   logic [LEN_W-1:0] beat_idx_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         len_q         <= '0;
         cnt_q         <= '0;
         wait_q        <= '0;
         last_q        <= 1'b0;
         bus.cmd_ready <= 1'b1;
         bus.busy      <= 1'b0;
         bus.req       <= 1'b1;
         bus.frame     <= 1'b1;
         bus.irdy      <= 1'b0;
         bus.bus_oe    <= 1'b0;
         bus.beat      <= 1'b0;
         bus.beat_idx  <= '0;
         bus.xfer_done <= 1'b0;
         bus.gnt_err   <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         wait_q        <= wait_d;
         last_q        <= last_d;
         bus.cmd_ready <= cmd_ready_d;
         bus.busy      <= busy_d;
         bus.req       <= req_d;
         bus.frame     <= frame_d;
         bus.irdy      <= irdy_d;
         bus.bus_oe    <= bus_oe_d;
         bus.beat      <= beat_d;
         bus.beat_idx  <= beat_idx_d;
         bus.xfer_done <= xfer_done_d;
         bus.gnt_err   <= gnt_err_d;
      end
   end

   // Outputs are decoded from the state being entered, so they line up with state_q after the edge.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      wait_d      = wait_q;
      last_d      = last_q;
      req_d       = 1'b1;
      frame_d     = 1'b1;
      irdy_d      = 1'b0;
      bus_oe_d    = 1'b0;
      beat_d      = 1'b0;
      beat_idx_d  = '0;
      xfer_done_d = 1'b0;
      gnt_err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               state_d = S_REQ;
               len_d   = bus.cmd_len;
               cnt_d   = '0;
               wait_d  = '0;
               last_d  = 1'b0;
            end
         end
         S_REQ: begin
            if (!bus.gnt) begin
               state_d = S_XFER;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_ABORT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_XFER: begin
            // A lost grant beats everything, including a pending final beat.
            if (bus.gnt) begin
               state_d = S_ABORT;
            end else if (last_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ABORT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // The counter saturates at len_q; last_q marks that the final beat has gone out.
      if (state_d == S_XFER && !bus.data_stall) begin
         beat_d     = 1'b1;
         beat_idx_d = cnt_q;
         if (cnt_q == len_q) begin
            last_d = 1'b1;
         end else begin
            cnt_d = cnt_q + LEN_W'(1);
         end
      end

      case (state_d)
         S_REQ: req_d = 1'b0;
         S_XFER: begin
            req_d    = 1'b0;
            bus_oe_d = 1'b1;
            frame_d  = 1'b0;
            irdy_d   = bus.data_stall;
         end
         S_DONE: begin
            irdy_d      = 1'b1;
            bus_oe_d    = 1'b1;
            xfer_done_d = 1'b1;
         end
         S_ABORT: gnt_err_d = 1'b1;
         default: ;
      endcase

      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
   end

endmodule
